sync_filter_shift_reg: RTL and testbench
========================================

Name: sync_filter_shift_reg

Overview:
- Parametrised successor to the fixed 1-bit, 3-stage, non-reset synchronizer wrapper.
- Synchronises a WIDTH-bit quasi-static input vector through a DEPTH-stage chain whose flops reset asynchronously to INIT.
- Optionally applies a word-level stability (glitch) filter and produces one-cycle rise/fall/change pulses.
- Sits at clock-domain boundaries for interrupt lines, straps and status bits entering the core clock domain.

Parameters:
- WIDTH, 1, number of independent bits synchronised.
- DEPTH, 3, synchronizer stages per bit; legal range 2..8. Elaboration error outside this range.
- INIT, 0, WIDTH-bit reset value of every stage and of the outputs.
- FILTER, 0, consecutive stable cycles required after synchronisation before q updates; 0 bypasses the filter. Legal range 0..255.

Ports:
- clock  input  1  sole clock; all flops are posedge.
- reset  input  1  asynchronous, active-high reset.
- io_d  input  WIDTH  asynchronous data in.
- io_q  output  WIDTH  synchronised (and filtered) data.
- io_rise  output  WIDTH  per-bit one-cycle pulse when a q bit goes 0->1.
- io_fall  output  WIDTH  per-bit one-cycle pulse when a q bit goes 1->0.
- io_changed  output  1  OR of io_rise and io_fall.
- io_stable  output  1  high when no input change is pending.

Behaviour:
- Reset is asynchronous, active-high, with one clock domain (clock).
- While reset is asserted, outputs are forced immediately, without waiting for a clock edge:
  - all chain stages, cand, q and q_d = INIT
  - cnt = FILTER
  - io_rise = io_fall = 0, io_changed = 0, io_stable = 1
- No pulses are generated on reset assertion or on reset release.
- Chain: per bit, stage0 <= d, stage k <= stage k-1. s = last stage. s reflects d after DEPTH edges. There is no combinational path from d.
- FILTER == 0:
  - io_q = s directly.
  - Latency is DEPTH edges.
  - io_stable = 1 when all stages of every bit are equal.
- FILTER > 0: cand (WIDTH bits) and cnt (clog2(FILTER+1) bits, saturating) are registered. Each edge:
  - if s != cand: cand <= s, cnt <= 0
  - else if cnt < FILTER: cnt <= cnt+1; when cnt == FILTER-1, q <= cand
  - else: hold
- Filter consequences:
  - A step on d reaches q after DEPTH+1+FILTER edges.
  - An excursion of s lasting <= FILTER cycles never reaches q.
  - An excursion lasting >= FILTER+1 cycles propagates.
  - io_stable = (cnt == FILTER) & (s == cand).
- Any change of s restarts the filter. The whole word must hold steady, so multi-bit coherency is filtered, not guaranteed.
- Edges: q_d <= q every cycle.
  - io_rise = q & ~q_d, io_fall = ~q & q_d; each is high for exactly the one cycle after q changes.
  - Simultaneous rise on some bits and fall on others is allowed and reported in the same cycle.
- Reset mid-filter discards the pending candidate. After release the block behaves as freshly reset.

Decomposition:
- Shared package (sync_pkg) holds:
  - the clog2 function
  - DEPTH/FILTER legal-range constants
  - the elaboration check macro
- One sub-module, sync_shift_reg_cell: a 1-bit DEPTH-stage async-reset chain with an init bit, instantiated WIDTH times.
  - Carries the synthesis keep/async-reg attributes so stages are never retimed or merged.
- Filter, counter and edge logic stay in the top module.

Test Plan:
- All scenarios use WIDTH=4, DEPTH=3, INIT=4'hA, FILTER=2 unless stated otherwise.
- Reset: assert reset mid-cycle -> q=4'hA, rise=fall=0, stable=1 before the next edge. Release with d=4'hA for 20 cycles -> no pulses, q stays 4'hA.
- Step: d 4'hA->4'h5 before edge 0, then held -> q=4'h5 after edge 6. rise=4'h5 and fall=4'hA for exactly one cycle; changed=1 for that cycle. stable=0 from edge 3 to edge 5, then 1 again.
- Glitch rejection: d=4'h5 for 2 cycles, then back to 4'hA -> q never leaves 4'hA, no pulses. Repeat with a 3-cycle pulse -> q=4'h5 for one or more cycles, with matching rise and fall pulses.
- Bypass: FILTER=0, DEPTH=2, d 0x0->0xF -> q=0xF after edge 2, rise=0xF for one cycle. Stable drops while the chain differs.
- Reset mid-filter: step d to 4'h5 and assert reset when cnt=1 -> q=4'hA immediately. Release with d=4'hA -> no pulses, q=4'hA. Release with d=4'h5 held -> q=4'h5 after 6 edges.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared definitions for the synchronizer family: legal parameter ranges,
// a constant-friendly clog2, the counter-width helper and the elaboration
// range-check macro used by every module in the family.

`ifndef SYNC_ELAB_CHECK
// Expands to a generate-if that stops elaboration with a message when cond is false.
`define SYNC_ELAB_CHECK(cond, label, msg) \
  if (!(cond)) begin : label \
    $error(msg); \
  end
`endif

package sync_pkg;

  // Synchronizer chain length limits: two flops is the minimum for metastability
  // settling, eight is the longest chain the family supports.
  localparam int unsigned DEPTH_MIN  = 2;
  localparam int unsigned DEPTH_MAX  = 8;

  // Upper limit of the stability filter length (counter fits in 8 bits).
  localparam int unsigned FILTER_MAX = 255;

  // Ceiling log2, usable in constant expressions; clog2(0) and clog2(1) are 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Width of the saturating stability counter; never below one bit so the
  // bypass configuration still has a well-formed (unused) counter type.
  function automatic int unsigned cnt_width(input int unsigned filter);
    int unsigned w;
    w = clog2(filter + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_shift_reg_cell.sv
// One bit of the synchronizer: a DEPTH-stage shift chain with asynchronous
// reset to INIT_BIT. The stages carry keep/async-reg attributes so synthesis
// never retimes, merges or packs them into shift-register primitives.

module sync_shift_reg_cell
  import sync_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter logic        INIT_BIT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic settled
);

  `SYNC_ELAB_CHECK((DEPTH >= DEPTH_MIN) && (DEPTH <= DEPTH_MAX), g_bad_depth,
                   "sync_shift_reg_cell: DEPTH must lie in 2..8")

  (* async_reg = "true", keep = "true" *) logic [DEPTH-1:0] stage;

  // Shift the asynchronous input through the chain; stage 0 is the capture flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage <= {DEPTH{INIT_BIT}};
    end else begin
      stage <= {stage[DEPTH-2:0], d};
    end
  end

  assign s       = stage[DEPTH-1];
  assign settled = (stage == {DEPTH{stage[0]}});

endmodule

// File: rtl/sync_filter_shift_reg.sv
// Multi-bit clock-domain-crossing synchronizer for quasi-static signals such
// as interrupt lines, straps and status bits. Each bit passes through its own
// DEPTH-stage chain; the synchronised word can optionally be run through a
// word-level stability filter before it reaches q. One-cycle rise/fall pulses
// are derived from q, and io_stable reports that nothing is still in flight.

module sync_filter_shift_reg
  import sync_pkg::*;
#(
  parameter int unsigned      WIDTH  = 1,
  parameter int unsigned      DEPTH  = 3,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter int unsigned      FILTER = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_d,
  output logic [WIDTH-1:0] io_q,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic             io_changed,
  output logic             io_stable
);

  localparam int unsigned      CNT_W   = cnt_width(FILTER);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER);

  `SYNC_ELAB_CHECK(WIDTH >= 1, g_bad_width,
                   "sync_filter_shift_reg: WIDTH must be at least 1")
  `SYNC_ELAB_CHECK((DEPTH >= DEPTH_MIN) && (DEPTH <= DEPTH_MAX), g_bad_depth,
                   "sync_filter_shift_reg: DEPTH must lie in 2..8")
  `SYNC_ELAB_CHECK(FILTER <= FILTER_MAX, g_bad_filter,
                   "sync_filter_shift_reg: FILTER must lie in 0..255")

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] settled;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_d;

  // Independent per-bit synchronizer chains; no combinational path from io_d.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_shift_reg_cell #(
      .DEPTH   (DEPTH),
      .INIT_BIT(INIT[i])
    ) u_cell (
      .clock  (clock),
      .reset  (reset),
      .d      (io_d[i]),
      .s      (s[i]),
      .settled(settled[i])
    );
  end

  if (FILTER == 0) begin : g_bypass

    assign q         = s;
    assign io_stable = &settled;

  end else begin : g_filter

    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    logic             unused_settled;

    assign unused_settled = ^settled;

    // Any change of the synchronised word restarts the count; q only takes the
    // candidate once it has been seen on FILTER+1 consecutive edges, so short
    // excursions die here. Reset leaves the filter saturated on INIT.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cand <= INIT;
        cnt  <= CNT_MAX;
        q    <= INIT;
      end else if (s != cand) begin
        cand <= s;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_MAX - CNT_W'(1)) begin
          q <= cand;
        end
      end
    end

    assign io_stable = (cnt == CNT_MAX) && (s == cand);

  end

  // Delayed copy of q for edge detection; reset to INIT so no pulse follows reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_d <= INIT;
    end else begin
      q_d <= q;
    end
  end

  assign io_q       = q;
  assign io_rise    = q & ~q_d;
  assign io_fall    = ~q & q_d;
  assign io_changed = |(io_rise | io_fall);

endmodule

// File: tb/tb_sync_filter_shift_reg.sv
// Bench for sync_filter_shift_reg. Two instances run side by side on one clock:
// a filtered one (WIDTH=4, DEPTH=3, INIT=4'hA, FILTER=2) and a bypass one
// (WIDTH=4, DEPTH=2, INIT=4'h0, FILTER=0). A behavioural model predicts every
// output each cycle from the history of sampled inputs; directed scenarios add
// hand-computed expectations at the interesting edges.

module tb_sync_filter_shift_reg;

  localparam int         M_DEPTH  = 3;
  localparam int         M_FILTER = 2;
  localparam logic [3:0] M_INIT   = 4'hA;
  localparam int         B_DEPTH  = 2;
  localparam logic [3:0] B_INIT   = 4'h0;

  logic       clock = 1'b0;
  logic       main_reset;
  logic       bypass_reset;
  logic [3:0] main_d;
  logic [3:0] bypass_d;

  logic [3:0] main_q, main_rise, main_fall;
  logic       main_changed, main_stable;
  logic [3:0] bypass_q, bypass_rise, bypass_fall;
  logic       bypass_changed, bypass_stable;

  int total_checks  = 0;
  int passed_checks = 0;

  always #5 clock = ~clock;

  sync_filter_shift_reg #(
    .WIDTH (4),
    .DEPTH (M_DEPTH),
    .INIT  (M_INIT),
    .FILTER(M_FILTER)
  ) u_dut_main (
    .clock     (clock),
    .reset     (main_reset),
    .io_d      (main_d),
    .io_q      (main_q),
    .io_rise   (main_rise),
    .io_fall   (main_fall),
    .io_changed(main_changed),
    .io_stable (main_stable)
  );

  sync_filter_shift_reg #(
    .WIDTH (4),
    .DEPTH (B_DEPTH),
    .INIT  (B_INIT),
    .FILTER(0)
  ) u_dut_bypass (
    .clock     (clock),
    .reset     (bypass_reset),
    .io_d      (bypass_d),
    .io_q      (bypass_q),
    .io_rise   (bypass_rise),
    .io_fall   (bypass_fall),
    .io_changed(bypass_changed),
    .io_stable (bypass_stable)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total_checks++;
    if (actual === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    #3;
  endtask

  // ---------------- behavioural model: filtered instance ----------------
  // chain[0] is the newest sample of d, chain[DEPTH-1] the synchronised word.
  // hist[] holds the last FILTER+1 synchronised words seen by the filter.
  logic [3:0] mm_chain [M_DEPTH];
  logic [3:0] mm_hist  [M_FILTER+1];
  logic [3:0] mm_q  = M_INIT;
  logic [3:0] mm_qd = M_INIT;

  always @(posedge clock or posedge main_reset) begin : main_model
    logic all_same;
    if (main_reset) begin
      for (int i = 0; i < M_DEPTH; i++) mm_chain[i] = M_INIT;
      for (int i = 0; i <= M_FILTER; i++) mm_hist[i] = M_INIT;
      mm_q  = M_INIT;
      mm_qd = M_INIT;
    end else begin
      for (int i = M_FILTER; i > 0; i--) mm_hist[i] = mm_hist[i-1];
      mm_hist[0] = mm_chain[M_DEPTH-1];
      all_same = 1'b1;
      for (int i = 1; i <= M_FILTER; i++) if (mm_hist[i] != mm_hist[0]) all_same = 1'b0;
      mm_qd = mm_q;
      if (all_same) mm_q = mm_hist[0];
      for (int i = M_DEPTH-1; i > 0; i--) mm_chain[i] = mm_chain[i-1];
      mm_chain[0] = main_d;
    end
  end

  // ---------------- behavioural model: bypass instance ----------------
  logic [3:0] bm_chain [B_DEPTH];
  logic [3:0] bm_qd = B_INIT;

  always @(posedge clock or posedge bypass_reset) begin : bypass_model
    if (bypass_reset) begin
      for (int i = 0; i < B_DEPTH; i++) bm_chain[i] = B_INIT;
      bm_qd = B_INIT;
    end else begin
      bm_qd = bm_chain[B_DEPTH-1];
      for (int i = B_DEPTH-1; i > 0; i--) bm_chain[i] = bm_chain[i-1];
      bm_chain[0] = bypass_d;
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always begin : compare
    logic       m_stable;
    logic       b_stable;
    logic [3:0] b_q;
    @(posedge clock);
    #3;
    m_stable = (mm_chain[M_DEPTH-1] == mm_hist[0]);
    for (int i = 1; i <= M_FILTER; i++) if (mm_hist[i] != mm_hist[0]) m_stable = 1'b0;
    check_output("model_main_q",       main_q,       mm_q);
    check_output("model_main_rise",    main_rise,    mm_q & ~mm_qd);
    check_output("model_main_fall",    main_fall,    ~mm_q & mm_qd);
    check_output("model_main_changed", main_changed, mm_q != mm_qd);
    check_output("model_main_stable",  main_stable,  m_stable);

    b_q      = bm_chain[B_DEPTH-1];
    b_stable = 1'b1;
    for (int i = 1; i < B_DEPTH; i++) if (bm_chain[i] != bm_chain[0]) b_stable = 1'b0;
    check_output("model_byp_q",       bypass_q,       b_q);
    check_output("model_byp_rise",    bypass_rise,    b_q & ~bm_qd);
    check_output("model_byp_fall",    bypass_fall,    ~b_q & bm_qd);
    check_output("model_byp_changed", bypass_changed, b_q != bm_qd);
    check_output("model_byp_stable",  bypass_stable,  b_stable);
  end

  // ---------------- directed scenarios ----------------
  task automatic apply_stimulus();
    int q5_cycles;
    int rise_cycles;
    int fall_cycles;

    main_reset   = 1'b1;
    bypass_reset = 1'b1;
    main_d       = M_INIT;
    bypass_d     = B_INIT;
    repeat (3) @(negedge clock);
    main_reset   = 1'b0;
    bypass_reset = 1'b0;

    // Idle after release: nothing moves.
    repeat (20) @(negedge clock);
    wait_edges(1);
    check_output("idle_q",      main_q,      4'hA);
    check_output("idle_stable", main_stable, 1'b1);

    // Step A -> 5 before edge 0; q follows after the sixth edge.
    @(negedge clock);
    main_d = 4'h5;
    wait_edges(3);
    check_output("step_e2_stable", main_stable, 1'b0);
    check_output("step_e2_q",      main_q,      4'hA);
    wait_edges(2);
    check_output("step_e4_q",      main_q,      4'hA);
    check_output("step_e4_stable", main_stable, 1'b0);
    wait_edges(1);
    check_output("step_e5_q",       main_q,       4'h5);
    check_output("step_e5_rise",    main_rise,    4'h5);
    check_output("step_e5_fall",    main_fall,    4'hA);
    check_output("step_e5_changed", main_changed, 1'b1);
    check_output("step_e5_stable",  main_stable,  1'b1);
    wait_edges(1);
    check_output("step_e6_rise",    main_rise,    4'h0);
    check_output("step_e6_changed", main_changed, 1'b0);
    check_output("step_e6_q",       main_q,       4'h5);

    // Asynchronous reset mid-cycle while q=5: outputs snap before any edge.
    @(negedge clock);
    #2 main_reset = 1'b1;
    #1;
    check_output("async_rst_q",       main_q,       4'hA);
    check_output("async_rst_rise",    main_rise,    4'h0);
    check_output("async_rst_fall",    main_fall,    4'h0);
    check_output("async_rst_changed", main_changed, 1'b0);
    check_output("async_rst_stable",  main_stable,  1'b1);
    main_d = 4'hA;
    @(negedge clock);
    @(negedge clock);
    main_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_edges(1);
      check_output("post_rst_q",       main_q,       4'hA);
      check_output("post_rst_changed", main_changed, 1'b0);
    end

    // Two-cycle excursion: rejected by the filter.
    @(negedge clock);
    main_d = 4'h5;
    repeat (2) @(negedge clock);
    main_d = 4'hA;
    for (int i = 0; i < 12; i++) begin
      wait_edges(1);
      check_output("glitch2_q",       main_q,       4'hA);
      check_output("glitch2_changed", main_changed, 1'b0);
    end

    // Three-cycle excursion: passes, q=5 for three cycles with one rise and one fall.
    @(negedge clock);
    main_d = 4'h5;
    repeat (3) @(negedge clock);
    main_d      = 4'hA;
    q5_cycles   = 0;
    rise_cycles = 0;
    fall_cycles = 0;
    for (int i = 0; i < 14; i++) begin
      wait_edges(1);
      if (main_q == 4'h5) q5_cycles++;
      if (main_rise == 4'h5) rise_cycles++;
      if (main_fall == 4'h5) fall_cycles++;
    end
    check_output("glitch3_q5_cycles", q5_cycles,   3);
    check_output("glitch3_rises",     rise_cycles, 1);
    check_output("glitch3_falls",     fall_cycles, 1);

    // Bypass instance: 0 -> F through a two-stage chain.
    @(negedge clock);
    bypass_d = 4'hF;
    wait_edges(1);
    check_output("byp_e0_q",      bypass_q,      4'h0);
    check_output("byp_e0_stable", bypass_stable, 1'b0);
    wait_edges(1);
    check_output("byp_e1_q",       bypass_q,       4'hF);
    check_output("byp_e1_rise",    bypass_rise,    4'hF);
    check_output("byp_e1_changed", bypass_changed, 1'b1);
    check_output("byp_e1_stable",  bypass_stable,  1'b1);
    wait_edges(1);
    check_output("byp_e2_rise", bypass_rise, 4'h0);

    // Reset while the filter count is 1: pending candidate is dropped.
    @(negedge clock);
    main_d = 4'h5;
    wait_edges(5);
    check_output("midfilt_pre_stable", main_stable, 1'b0);
    #4 main_reset = 1'b1;
    #1;
    check_output("midfilt_rst_q",      main_q,      4'hA);
    check_output("midfilt_rst_stable", main_stable, 1'b1);
    main_d = 4'hA;
    @(negedge clock);
    @(negedge clock);
    main_reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wait_edges(1);
      check_output("midfilt_idle_q",       main_q,       4'hA);
      check_output("midfilt_idle_changed", main_changed, 1'b0);
    end

    // Release with 5 already on d: behaves like a fresh step.
    @(negedge clock);
    main_reset = 1'b1;
    main_d     = 4'h5;
    @(negedge clock);
    main_reset = 1'b0;
    wait_edges(5);
    check_output("rel5_e4_q", main_q, 4'hA);
    wait_edges(1);
    check_output("rel5_e5_q",    main_q,    4'h5);
    check_output("rel5_e5_rise", main_rise, 4'h5);
    @(negedge clock);
  endtask

  initial begin
    apply_stimulus();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
